// File: rtl/uart_pattern_ctrl_if.sv
// Bundles the UART line and the decoded panel settings between the control
// stage and its environment.
interface uart_pattern_ctrl_if;
    logic       usb_rx;
    logic [1:0] pattern_sel;
    logic [5:0] fill_red;
    logic [5:0] fill_green;
    logic [5:0] fill_blue;
    logic [7:0] bl_duty;
    logic       led_pwm;
    logic       cmd_ok;
    logic       cmd_err;

    // Environment side: drives the UART line, observes the settings.
    modport master (
        output usb_rx,
        input  pattern_sel, fill_red, fill_green, fill_blue,
        input  bl_duty, led_pwm, cmd_ok, cmd_err
    );

    // Control stage side.
    modport slave (
        input  usb_rx,
        output pattern_sel, fill_red, fill_green, fill_blue,
        output bl_duty, led_pwm, cmd_ok, cmd_err
    );
endinterface

// File: rtl/uart_pattern_ctrl.sv
// UART command receiver for the panel pipeline: decodes A5/ADDR/DATA/CSUM
// packets into pattern and fill-colour settings and drives backlight PWM.
module uart_pattern_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 32,
    parameter int PWM_DIV      = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_pattern_ctrl_if.slave  bus
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int PRESC_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_LIMIT - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_DIV - 1);
    localparam logic [7:0]         SYNC_BYTE  = 8'hA5;
    localparam logic [7:0]         PWM_TOP    = 8'd254;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_CSUM}     p_state_t;

    // ---------------- state declarations ----------------
    logic              rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;

    p_state_t          p_state_q, p_state_d;
    logic [7:0]        addr_q, addr_d, data_q, data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [1:0]        pattern_sel_q, pattern_sel_d;
    logic [5:0]        fill_red_q, fill_red_d;
    logic [5:0]        fill_green_q, fill_green_d;
    logic [5:0]        fill_blue_q, fill_blue_d;
    logic [7:0]        bl_duty_q, bl_duty_d;
    logic              cmd_ok_q, cmd_ok_d, cmd_err_q, cmd_err_d;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic               led_pwm_q, led_pwm_d;

    // Two-flop synchroniser for the asynchronous RX line.
    always_comb begin
        rx_meta_d = bus.usb_rx;
        rx_sync_d = rx_meta_q;
    end

    // RX bit timing: start validation, 8 data bits LSB first, one stop sample.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // A line already back high mid-start-bit was only a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_sync_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d    = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Packet parser, inter-byte timeout and register writes.
    always_comb begin
        p_state_d     = p_state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        to_cnt_d      = (p_state_q == P_IDLE) ? '0 : to_cnt_q + 1'b1;
        pattern_sel_d = pattern_sel_q;
        fill_red_d    = fill_red_q;
        fill_green_d  = fill_green_q;
        fill_blue_d   = fill_blue_q;
        bl_duty_d     = bl_duty_q;
        cmd_ok_d      = 1'b0;
        cmd_err_d     = 1'b0;
        if (frame_err_q) begin
            // Framing error dominates; a coincident timeout folds into it.
            cmd_err_d = 1'b1;
            p_state_d = P_IDLE;
            to_cnt_d  = '0;
        end else if (byte_valid_q) begin
            to_cnt_d = '0;
            case (p_state_q)
                P_IDLE: if (shreg_q == SYNC_BYTE) p_state_d = P_ADDR;
                P_ADDR: begin
                    addr_d    = shreg_q;
                    p_state_d = P_DATA;
                end
                P_DATA: begin
                    data_d    = shreg_q;
                    p_state_d = P_CSUM;
                end
                default: begin
                    p_state_d = P_IDLE;
                    if (shreg_q == (addr_q ^ data_q) && addr_q <= 8'd4) begin
                        cmd_ok_d = 1'b1;
                        case (addr_q[2:0])
                            3'd0:    pattern_sel_d = data_q[1:0];
                            3'd1:    fill_red_d    = data_q[5:0];
                            3'd2:    fill_green_d  = data_q[5:0];
                            3'd3:    fill_blue_d   = data_q[5:0];
                            default: bl_duty_d     = data_q;
                        endcase
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end else if (p_state_q != P_IDLE && to_cnt_q == TO_LAST) begin
            cmd_err_d = 1'b1;
            p_state_d = P_IDLE;
            to_cnt_d  = '0;
        end
    end

    // Backlight PWM: prescaled 255-step counter compared against the duty.
    always_comb begin
        presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        if (presc_q == PRESC_LAST)
            pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + 1'b1;
        led_pwm_d = (pwm_cnt_q < bl_duty_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: synchroniser flops reset to the idle-high line level so
            // reset release is not mistaken for a start bit.
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            byte_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            p_state_q     <= P_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            to_cnt_q      <= '0;
            pattern_sel_q <= '0;
            fill_red_q    <= '0;
            fill_green_q  <= '0;
            fill_blue_q   <= '0;
            bl_duty_q     <= 8'hFF;
            cmd_ok_q      <= 1'b0;
            cmd_err_q     <= 1'b0;
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            led_pwm_q     <= 1'b1;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            byte_valid_q  <= byte_valid_d;
            frame_err_q   <= frame_err_d;
            p_state_q     <= p_state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            to_cnt_q      <= to_cnt_d;
            pattern_sel_q <= pattern_sel_d;
            fill_red_q    <= fill_red_d;
            fill_green_q  <= fill_green_d;
            fill_blue_q   <= fill_blue_d;
            bl_duty_q     <= bl_duty_d;
            cmd_ok_q      <= cmd_ok_d;
            cmd_err_q     <= cmd_err_d;
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_pwm_q     <= led_pwm_d;
        end
    end

    assign bus.pattern_sel = pattern_sel_q;
    assign bus.fill_red    = fill_red_q;
    assign bus.fill_green  = fill_green_q;
    assign bus.fill_blue   = fill_blue_q;
    assign bus.bl_duty     = bl_duty_q;
    assign bus.led_pwm     = led_pwm_q;
    assign bus.cmd_ok      = cmd_ok_q;
    assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_uart_pattern_ctrl.sv
// Self-checking bench for uart_pattern_ctrl: directed scenarios followed by
// random packets, all compared against a register-map model of the packet rules.
module tb_uart_pattern_ctrl;

    localparam int CPB     = 16;
    localparam int TO_BITS = 32;
    localparam int PDIV    = 2;
    localparam int PERIOD  = 255 * PDIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_pattern_ctrl_if bus_if ();

    uart_pattern_ctrl #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TO_BITS),
        .PWM_DIV      (PDIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Pulse monitor, written only here.
    int ok_seen   = 0;
    int err_seen  = 0;
    int both_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.cmd_ok) ok_seen++;
            if (bus_if.cmd_err) err_seen++;
            if (bus_if.cmd_ok && bus_if.cmd_err) both_seen++;
        end
    end

    // Reference model: register file indexed by address plus pulse tallies.
    logic [7:0] m_reg [5];
    int exp_ok  = 0;
    int exp_err = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_reg[4] = 8'hFF;
    endtask

    task automatic model_packet(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        if (c == (a ^ d) && a < 8'd5) begin
            m_reg[a[2:0]] = d;
            exp_ok++;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pattern_sel"}, 32'(bus_if.pattern_sel), 32'(m_reg[0][1:0]));
        check({tag, ".fill_red"},    32'(bus_if.fill_red),    32'(m_reg[1][5:0]));
        check({tag, ".fill_green"},  32'(bus_if.fill_green),  32'(m_reg[2][5:0]));
        check({tag, ".fill_blue"},   32'(bus_if.fill_blue),   32'(m_reg[3][5:0]));
        check({tag, ".bl_duty"},     32'(bus_if.bl_duty),     32'(m_reg[4]));
    endtask

    task automatic check_pulses(input string tag);
        check({tag, ".ok_count"},  32'(ok_seen),  32'(exp_ok));
        check({tag, ".err_count"}, 32'(err_seen), 32'(exp_err));
    endtask

    task automatic idle_bits(input int n);
        bus_if.usb_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus_if.usb_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_level);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_level);
        bus_if.usb_rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
        send_byte(c, 1'b1);
        model_packet(a, d, c);
        idle_bits(2);
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (bus_if.led_pwm) n++;
        end
    endtask

    initial begin
        int hi;
        logic [7:0] a, d, c;

        // Reset with an idle line.
        bus_if.usb_rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_regs("reset");
        check("reset.led_pwm", 32'(bus_if.led_pwm), 32'd1);
        check_pulses("reset");
        count_high(hi);
        check("reset.pwm_period1", 32'(hi), 32'(PERIOD));
        count_high(hi);
        check("reset.pwm_period2", 32'(hi), 32'(PERIOD));

        // Fill red write.
        send_pkt(8'h01, 8'h2A, 8'h2B);
        check_regs("red");
        check_pulses("red");

        // Backlight duty 64/255, then zero.
        send_pkt(8'h04, 8'h40, 8'h44);
        count_high(hi);
        check("pwm.duty64", 32'(hi), 32'(64 * PDIV));
        send_pkt(8'h04, 8'h00, 8'h04);
        count_high(hi);
        check("pwm.duty0", 32'(hi), 32'd0);
        check_regs("duty");

        // Bad checksum, then bad address.
        send_pkt(8'h02, 8'h11, 8'h00);
        send_pkt(8'h07, 8'h01, 8'h06);
        check_regs("bad_pkts");
        check_pulses("bad_pkts");

        // Inter-byte timeout, then trailing bytes discarded.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(30);
        check_pulses("timeout.before");
        idle_bits(4);
        exp_err++;
        check_pulses("timeout.after");
        idle_bits(6);
        send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_bits(2);
        check_regs("timeout.trail");
        check_pulses("timeout.trail");

        // Short low glitch.
        bus_if.usb_rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        check_pulses("glitch");

        // Stop bit held low.
        send_byte(8'h55, 1'b0);
        exp_err++;
        idle_bits(2);
        check_pulses("framing");

        // Reset in the middle of the DATA byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        bus_if.usb_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_bits(12);
        check_regs("mid_reset");
        check_pulses("mid_reset");
        send_pkt(8'h03, 8'h3F, 8'h3C);
        check_regs("resend");
        check_pulses("resend");

        // Random packets, mostly with correct checksums.
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom_range(0, 7));
            d = 8'($urandom);
            c = a ^ d;
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_pkt(a, d, c);
            check_regs("random");
            check_pulses("random");
        end

        check("exclusive_pulses", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
